// File: rtl/sym_counter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sym_counter_pkg
// Description : Shared widths, FSM state encoding and helpers for the
//               SymCounter game-flow controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sym_counter_pkg;

  // Datapath widths
  localparam int LEVEL_W = 4;
  localparam int SECS_W  = 4;
  localparam int LIVES_W = 2;

  // Explicit state encoding, kept stable so debug probes can decode it
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_COUNT   = 3'd2;
  localparam logic [2:0] ST_PLAY    = 3'd3;
  localparam logic [2:0] ST_ADVANCE = 3'd4;
  localparam logic [2:0] ST_FAIL    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ARM     = ST_ARM,
    S_COUNT   = ST_COUNT,
    S_PLAY    = ST_PLAY,
    S_ADVANCE = ST_ADVANCE,
    S_FAIL    = ST_FAIL,
    S_DONE    = ST_DONE
  } state_e;

  // Elaboration-time range check used on the configuration parameters
  function automatic logic in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/play_window_timer.sv
`default_nettype none
// ============================================================================
// Module      : play_window_timer
// Description : Loadable seconds down-counter for the answer window. Counts
//               down on each enabled tick, freezes when the enable is low,
//               and flags the tick that takes the count from 1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module play_window_timer
  import sym_counter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [SECS_W-1:0] load_val_i,
  input  logic              en_i,
  output logic [SECS_W-1:0] secs_o,
  output logic              expire_o
);

  logic [SECS_W-1:0] secs_q;
  logic [SECS_W-1:0] secs_d;

  // Next count: a load wins over the enable, and the count never wraps below zero
  always_comb begin
    secs_d = secs_q;
    if (load_i) begin
      secs_d = load_val_i;
    end else if (en_i && (secs_q != '0)) begin
      secs_d = secs_q - SECS_W'(1);
    end
  end

  // Count register, cleared by the asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      secs_q <= '0;
    end else begin
      secs_q <= secs_d;
    end
  end

  assign secs_o = secs_q;

  // Combinational so the sequencer can leave the window on the same edge
  // that the count reaches zero
  assign expire_o = en_i && !load_i && (secs_q == SECS_W'(1));

endmodule
`default_nettype wire

// File: rtl/level_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : level_sequencer
// Description : Game-flow controller for the SymCounter datapath. Starts the
//               countdown timer, opens a timed answer window, judges the
//               answer and advances the level until the game is won or lost.
//               Optional feature macro: LEVEL_SEQ_LIVES_EN (multiple lives
//               with retry of the current level on a failed round).
// Revision    : 1.0 - initial release
// ============================================================================
module level_sequencer
  import sym_counter_pkg::*;
#(
  parameter int MAX_LEVEL = 9,
  parameter int PLAY_SECS = 10,
  parameter int LIVES     = 3
) (
  input  logic               Clk100M,
  input  logic               rstN,
  input  logic               tick1Hz,
  input  logic               startBtn,
  input  logic               timerDone,
  input  logic               answerValid,
  input  logic               answerCorrect,
  output logic               timerStart,
  output logic [LEVEL_W-1:0] curLevel,
  output logic               playActive,
  output logic [SECS_W-1:0]  secsLeft,
  output logic [LIVES_W-1:0] livesLeft,
  output logic               gameWon,
  output logic               gameOver
);

  // Reject configurations outside the supported ranges at elaboration
  if (!in_range(MAX_LEVEL, 1, 15) || !in_range(PLAY_SECS, 1, 15) ||
      !in_range(LIVES, 1, 3)) begin : g_bad_params
    $error("level_sequencer: MAX_LEVEL/PLAY_SECS/LIVES out of range");
  end

  localparam logic [LEVEL_W-1:0] MAX_LEVEL_C  = LEVEL_W'(MAX_LEVEL);
  localparam logic [SECS_W-1:0]  PLAY_SECS_C  = SECS_W'(PLAY_SECS);
  localparam logic [LEVEL_W-1:0] FIRST_LEVEL  = LEVEL_W'(1);

`ifdef LEVEL_SEQ_LIVES_EN
  localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(LIVES);
`else
  localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(1);
`endif

  state_e             state_q;
  logic [LEVEL_W-1:0] level_q;
  logic               timer_start_q;
  logic               play_active_q;
  logic               game_won_q;
  logic               game_over_q;
`ifdef LEVEL_SEQ_LIVES_EN
  logic [LIVES_W-1:0] lives_q;
`endif

  logic               timer_load;
  logic               timer_en;
  logic               timer_expire;
  logic [SECS_W-1:0]  secs_left;

  // The window loads on the edge that enters PLAY; an answer in the same
  // cycle as a tick takes priority, so the tick is suppressed
  assign timer_load = (state_q == S_COUNT) && timerDone;
  assign timer_en   = (state_q == S_PLAY) && tick1Hz && !answerValid;

  play_window_timer u_play_window_timer (
    .clk_i      (Clk100M),
    .rst_ni     (rstN),
    .load_i     (timer_load),
    .load_val_i (PLAY_SECS_C),
    .en_i       (timer_en),
    .secs_o     (secs_left),
    .expire_o   (timer_expire)
  );

  // Game-flow FSM with level counter, lives counter and registered flags
  always_ff @(posedge Clk100M or negedge rstN) begin
    if (!rstN) begin
      state_q       <= S_IDLE;
      level_q       <= FIRST_LEVEL;
      timer_start_q <= 1'b0;
      play_active_q <= 1'b0;
      game_won_q    <= 1'b0;
      game_over_q   <= 1'b0;
`ifdef LEVEL_SEQ_LIVES_EN
      lives_q       <= LIVES_INIT;
`endif
    end else begin
      // timerStart is a single-cycle pulse: only the edge entering ARM sets it
      timer_start_q <= 1'b0;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (startBtn) begin
            level_q       <= FIRST_LEVEL;
            game_won_q    <= 1'b0;
            game_over_q   <= 1'b0;
            timer_start_q <= 1'b1;
`ifdef LEVEL_SEQ_LIVES_EN
            lives_q       <= LIVES_INIT;
`endif
            state_q       <= S_ARM;
          end
        end

        S_ARM: begin
          state_q <= S_COUNT;
        end

        S_COUNT: begin
          if (timerDone) begin
            play_active_q <= 1'b1;
            state_q       <= S_PLAY;
          end
        end

        S_PLAY: begin
          if (answerValid) begin
            play_active_q <= 1'b0;
            state_q       <= answerCorrect ? S_ADVANCE : S_FAIL;
          end else if (timer_expire) begin
            play_active_q <= 1'b0;
            state_q       <= S_FAIL;
          end
        end

        S_ADVANCE: begin
          // The compare guards the increment, so the level never wraps
          if (level_q == MAX_LEVEL_C) begin
            game_won_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            level_q       <= level_q + LEVEL_W'(1);
            timer_start_q <= 1'b1;
            state_q       <= S_ARM;
          end
        end

        S_FAIL: begin
`ifdef LEVEL_SEQ_LIVES_EN
          if (lives_q <= LIVES_W'(1)) begin
            lives_q     <= '0;
            game_over_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            // Retry the same level with one life fewer
            lives_q       <= lives_q - LIVES_W'(1);
            timer_start_q <= 1'b1;
            state_q       <= S_ARM;
          end
`else
          game_over_q <= 1'b1;
          state_q     <= S_DONE;
`endif
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign timerStart = timer_start_q;
  assign curLevel   = level_q;
  assign playActive = play_active_q;
  assign secsLeft   = secs_left;
  assign gameWon    = game_won_q;
  assign gameOver   = game_over_q;
`ifdef LEVEL_SEQ_LIVES_EN
  assign livesLeft  = lives_q;
`else
  assign livesLeft  = LIVES_INIT;
`endif

endmodule
`default_nettype wire
